// File: rtl/euler_stepper.sv
// euler_stepper
// Fixed-point forward-Euler integrator: x <- x + h*(A*x + B*u), repeated STEPS
// times over an n-element state and m-element input held in a shared
// dual-read-port RAM (synchronous read, data one cycle after address).
//
// Ports
//   i_clk               clock, all state changes on the rising edge
//   i_rst               asynchronous active-high reset
//   i_start             run request, only sampled while idle
//   o_rd_add1/2         read addresses (port 1: matrices/header, port 2: vectors/header)
//   i_rd_data1/2        read data returned one cycle after the address
//   o_wr_en/add/data    write port, used only while writing back the new state
//   o_busy              run in progress
//   o_done              one-cycle completion pulse
//   o_err               header of the last run was rejected
//   o_ovf               sticky: some saturation happened during the last run
module euler_stepper #(
    parameter int ADDRESS_WIDTH = 13,
    parameter int DATA_WIDTH    = 16,
    parameter int FRAC_BITS     = 8,
    parameter int MAX_N         = 8,
    parameter int MAX_M         = 8,
    parameter int HDR_BASE      = 0,
    parameter int A_BASE        = 16,
    parameter int B_BASE        = 96,
    parameter int U_BASE        = 176,
    parameter int X_BASE        = 192
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    output logic [ADDRESS_WIDTH-1:0] o_rd_add1,
    output logic [ADDRESS_WIDTH-1:0] o_rd_add2,
    input  logic [DATA_WIDTH-1:0]    i_rd_data1,
    input  logic [DATA_WIDTH-1:0]    i_rd_data2,
    output logic                     o_wr_en,
    output logic [ADDRESS_WIDTH-1:0] o_wr_add,
    output logic [DATA_WIDTH-1:0]    o_wr_data,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err,
    output logic                     o_ovf
);

    localparam int ACC_W = 2 * DATA_WIDTH + 4;
    localparam int IDX_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    typedef logic [ADDRESS_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0]    word_t;

    localparam addr_t HDR_A   = addr_t'(HDR_BASE);
    localparam addr_t A_A     = addr_t'(A_BASE);
    localparam addr_t B_A     = addr_t'(B_BASE);
    localparam addr_t U_A     = addr_t'(U_BASE);
    localparam addr_t X_A     = addr_t'(X_BASE);
    localparam addr_t ONE_A   = addr_t'(1);
    localparam addr_t TWO_A   = addr_t'(2);
    localparam addr_t THREE_A = addr_t'(3);
    localparam word_t ONE_W   = word_t'(1);
    localparam word_t MAX_N_W = word_t'(MAX_N);
    localparam word_t MAX_M_W = word_t'(MAX_M);

    // Saturation limits sign-extended to accumulator width
    localparam logic signed [ACC_W-1:0] SAT_HI =
        {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO =
        {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_HDR0  = 4'd1,
        S_HDR1  = 4'd2,
        S_CHECK = 4'd3,
        S_MAC_A = 4'd4,
        S_MAC_B = 4'd5,
        S_UPD   = 4'd6,
        S_WB    = 4'd7,
        S_FIN   = 4'd8
    } state_t;

    // Clamp to the signed word range; MSB of the result flags a clamp
    function automatic logic [DATA_WIDTH:0] sat_q(input logic signed [ACC_W-1:0] v);
        logic [DATA_WIDTH:0] res;
        if (v > SAT_HI) begin
            res = {1'b1, SAT_HI[DATA_WIDTH-1:0]};
        end else if (v < SAT_LO) begin
            res = {1'b1, SAT_LO[DATA_WIDTH-1:0]};
        end else begin
            res = {1'b0, v[DATA_WIDTH-1:0]};
        end
        return res;
    endfunction

    state_t r_state, w_state_nxt;
    word_t  r_cnt, w_cnt_nxt;
    word_t  r_row, r_n, r_m, r_h, r_steps;
    addr_t  r_pa, r_pb, w_pa_cur;
    logic   r_mac_iss, r_dv;
    logic signed [ACC_W-1:0] r_acc;
    word_t  r_buf [0:MAX_N-1];

    addr_t  r_rd_add1, r_rd_add2, r_wr_add;
    word_t  r_wr_data;
    logic   r_wr_en, r_busy, r_done, r_err, r_ovf;

    logic   w_hdr_bad, w_last_row, w_step_start;
    logic   w_iss_a, w_iss_b, w_iss_x, w_wr, w_upd_fire, w_upd_ovf;
    addr_t  w_rd1_nxt, w_rd2_nxt;
    word_t  w_wb_data, w_y;

    logic signed [2*DATA_WIDTH-1:0] w_mac_p, w_prod_h, w_prod_sh;
    logic signed [ACC_W-1:0]        w_acc_sh, w_sum;
    logic [DATA_WIDTH:0]            w_sat_d, w_sat_p, w_sat_y;

    assign o_rd_add1 = r_rd_add1;
    assign o_rd_add2 = r_rd_add2;
    assign o_wr_en   = r_wr_en;
    assign o_wr_add  = r_wr_add;
    assign o_wr_data = r_wr_data;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_err     = r_err;
    assign o_ovf     = r_ovf;

    // Next-state logic and the within-state cycle counter
    always_comb begin
        w_state_nxt = r_state;
        w_hdr_bad   = (r_n == '0) || (r_n > MAX_N_W) || (r_m > MAX_M_W) || (i_rd_data2 == '0);
        w_last_row  = (r_row == (r_n - ONE_W));
        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_nxt = S_HDR0;
                else         w_state_nxt = S_IDLE;
            end
            S_HDR0:  w_state_nxt = S_HDR1;
            S_HDR1:  w_state_nxt = S_CHECK;
            S_CHECK: begin
                if (w_hdr_bad) w_state_nxt = S_FIN;
                else           w_state_nxt = S_MAC_A;
            end
            S_MAC_A: begin
                if (r_cnt == r_n) w_state_nxt = S_MAC_B;
                else              w_state_nxt = S_MAC_A;
            end
            S_MAC_B: begin
                if (r_cnt == r_m) w_state_nxt = S_UPD;
                else              w_state_nxt = S_MAC_B;
            end
            S_UPD: begin
                if (r_cnt == ONE_W) begin
                    if (w_last_row) w_state_nxt = S_WB;
                    else            w_state_nxt = S_MAC_A;
                end else begin
                    w_state_nxt = S_UPD;
                end
            end
            S_WB: begin
                if (r_cnt == (r_n - ONE_W)) begin
                    if (r_steps == ONE_W) w_state_nxt = S_FIN;
                    else                  w_state_nxt = S_MAC_A;
                end else begin
                    w_state_nxt = S_WB;
                end
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        if ((w_state_nxt == r_state) && (r_state != S_IDLE)) w_cnt_nxt = r_cnt + ONE_W;
        else                                                 w_cnt_nxt = '0;

        w_step_start = (w_state_nxt == S_MAC_A) && ((r_state == S_CHECK) || (r_state == S_WB));
        w_upd_fire   = (r_state == S_UPD) && (r_cnt == ONE_W);
    end

    // Decide what the next cycle issues; addresses are registered so they
    // are computed from the next state and next counter value
    always_comb begin
        w_iss_a   = (w_state_nxt == S_MAC_A) && (w_cnt_nxt < r_n);
        w_iss_b   = (w_state_nxt == S_MAC_B) && (w_cnt_nxt < r_m);
        w_iss_x   = (w_state_nxt == S_UPD) && (w_cnt_nxt == '0);
        w_wr      = (w_state_nxt == S_WB);
        w_pa_cur  = w_step_start ? A_A : r_pa;
        w_rd1_nxt = '0;
        w_rd2_nxt = '0;
        if (w_iss_a) begin
            w_rd1_nxt = w_pa_cur;
            w_rd2_nxt = X_A + addr_t'(w_cnt_nxt);
        end else if (w_iss_b) begin
            w_rd1_nxt = r_pb;
            w_rd2_nxt = U_A + addr_t'(w_cnt_nxt);
        end else if (w_iss_x) begin
            w_rd1_nxt = HDR_A;
            w_rd2_nxt = X_A + addr_t'(r_row);
        end else if (w_state_nxt == S_HDR0) begin
            w_rd1_nxt = HDR_A;
            w_rd2_nxt = HDR_A + ONE_A;
        end else if (w_state_nxt == S_HDR1) begin
            w_rd1_nxt = HDR_A + TWO_A;
            w_rd2_nxt = HDR_A + THREE_A;
        end else begin
            w_rd1_nxt = HDR_A;
            w_rd2_nxt = HDR_A;
        end
    end

    // Row update: d = sat(acc>>>F), y = sat(x + sat((h*d)>>>F)), x from RD2
    always_comb begin
        w_mac_p   = $signed(i_rd_data1) * $signed(i_rd_data2);
        w_acc_sh  = r_acc >>> FRAC_BITS;
        w_sat_d   = sat_q(w_acc_sh);
        w_prod_h  = $signed(r_h) * $signed(w_sat_d[DATA_WIDTH-1:0]);
        w_prod_sh = w_prod_h >>> FRAC_BITS;
        w_sat_p   = sat_q({{(ACC_W-2*DATA_WIDTH){w_prod_sh[2*DATA_WIDTH-1]}}, w_prod_sh});
        w_sum     = $signed({{(ACC_W-DATA_WIDTH){i_rd_data2[DATA_WIDTH-1]}}, i_rd_data2})
                  + $signed({{(ACC_W-DATA_WIDTH){w_sat_p[DATA_WIDTH-1]}}, w_sat_p[DATA_WIDTH-1:0]});
        w_sat_y   = sat_q(w_sum);
        w_y       = w_sat_y[DATA_WIDTH-1:0];
        w_upd_ovf = w_sat_d[DATA_WIDTH] | w_sat_p[DATA_WIDTH] | w_sat_y[DATA_WIDTH];
        // With n=1 the only row is stored on the same edge write-back starts
        if (w_upd_fire && (w_cnt_nxt == r_row)) w_wb_data = w_y;
        else                                    w_wb_data = r_buf[w_cnt_nxt[IDX_W-1:0]];
    end

    // State register and cycle counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Header capture, step/row bookkeeping and matrix read pointers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_n     <= '0;
            r_m     <= '0;
            r_h     <= '0;
            r_steps <= '0;
            r_row   <= '0;
            r_pa    <= '0;
            r_pb    <= '0;
        end else begin
            if (r_state == S_HDR1) begin
                r_n <= i_rd_data1;
                r_m <= i_rd_data2;
            end
            if (r_state == S_CHECK) begin
                r_h     <= i_rd_data1;
                r_steps <= i_rd_data2;
                r_row   <= '0;
            end else if (w_upd_fire) begin
                r_row <= w_last_row ? '0 : (r_row + ONE_W);
            end else if ((r_state == S_WB) && (w_state_nxt != S_WB)) begin
                r_steps <= r_steps - ONE_W;
            end
            // A and B are walked row-major by plain increments across rows
            if (w_iss_a) r_pa <= w_pa_cur + ONE_A;
            if (w_step_start)  r_pb <= B_A;
            else if (w_iss_b)  r_pb <= r_pb + ONE_A;
        end
    end

    // Accumulator (data arrives one cycle after each issue) and new-state buffer
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mac_iss <= 1'b0;
            r_dv      <= 1'b0;
            r_acc     <= '0;
            for (int i = 0; i < MAX_N; i++) r_buf[i] <= '0;
        end else begin
            r_mac_iss <= w_iss_a | w_iss_b;
            r_dv      <= r_mac_iss;
            if ((w_state_nxt == S_MAC_A) && (r_state != S_MAC_A)) begin
                r_acc <= '0;
            end else if (r_dv) begin
                r_acc <= r_acc + $signed({{(ACC_W-2*DATA_WIDTH){w_mac_p[2*DATA_WIDTH-1]}}, w_mac_p});
            end
            if (w_upd_fire) r_buf[r_row[IDX_W-1:0]] <= w_y;
        end
    end

    // Registered outputs: RAM ports, handshake and status flags
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_add1 <= '0;
            r_rd_add2 <= '0;
            r_wr_en   <= 1'b0;
            r_wr_add  <= '0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_rd_add1 <= w_rd1_nxt;
            r_rd_add2 <= w_rd2_nxt;
            r_wr_en   <= w_wr;
            if (w_wr) begin
                r_wr_add  <= X_A + addr_t'(w_cnt_nxt);
                r_wr_data <= w_wb_data;
            end else begin
                r_wr_add  <= '0;
                r_wr_data <= '0;
            end
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (r_state == S_FIN);
            if ((r_state == S_IDLE) && i_start) begin
                r_err <= 1'b0;
                r_ovf <= 1'b0;
            end else begin
                if ((r_state == S_CHECK) && w_hdr_bad) r_err <= 1'b1;
                if (w_upd_fire && w_upd_ovf)          r_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_euler_stepper.sv
module tb_euler_stepper;
    localparam int AW = 13, DW = 16, MAXN = 8, MAXM = 8;
    localparam int XB = 192, AB = 16, BB = 96, UB = 176;

    logic clk = 1'b0;
    logic rst, start;
    logic [AW-1:0] rd_add1, rd_add2, wr_add;
    logic [DW-1:0] rd_data1, rd_data2, wr_data;
    logic wr_en, busy, done, err, ovf;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic tb_we = 1'b0;
    logic [AW-1:0] tb_a = '0;
    logic [DW-1:0] tb_d = '0;

    int n_chk = 0, n_fail = 0, done_cnt = 0, wr_cnt = 0;

    // scenario under test
    int am [MAXN][MAXN];
    int bm [MAXN][MAXM];
    int um [MAXM];
    int xm [MAXN];
    int cn, cm, ch, cs;
    bit m_ovf;

    euler_stepper dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .o_rd_add1(rd_add1), .o_rd_add2(rd_add2),
        .i_rd_data1(rd_data1), .i_rd_data2(rd_data2),
        .o_wr_en(wr_en), .o_wr_add(wr_add), .o_wr_data(wr_data),
        .o_busy(busy), .o_done(done), .o_err(err), .o_ovf(ovf)
    );

    always #5 clk = ~clk;

    // shared RAM: synchronous read, DUT write has priority over bench loading
    always @(posedge clk) begin
        if (wr_en) mem[wr_add] <= wr_data;
        else if (tb_we) mem[tb_a] <= tb_d;
        rd_data1 <= mem[rd_add1];
        rd_data2 <= mem[rd_add2];
    end

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (wr_en) begin
            wr_cnt++;
            check_eq("wr_during_x_read", longint'(rd_add2 >= AW'(XB) && rd_add2 < AW'(XB + MAXN)), 0);
        end
    end

    function automatic int satq(input longint v);
        if (v > 32767) begin m_ovf = 1'b1; return 32767; end
        else if (v < -32768) begin m_ovf = 1'b1; return -32768; end
        else return int'(v);
    endfunction

    // reference: x <- sat(x + sat(h*sat((A x + B u)>>>F) >>> F)), all rows from old x
    task automatic model_steps(input int steps);
        int xn [MAXN];
        longint acc;
        int d, p;
        for (int s = 0; s < steps; s++) begin
            for (int i = 0; i < cn; i++) begin
                acc = 0;
                for (int j = 0; j < cn; j++) acc += longint'(am[i][j]) * longint'(xm[j]);
                for (int k = 0; k < cm; k++) acc += longint'(bm[i][k]) * longint'(um[k]);
                d = satq(acc >>> 8);
                p = satq((longint'(ch) * longint'(d)) >>> 8);
                xn[i] = satq(longint'(xm[i]) + longint'(p));
            end
            for (int i = 0; i < cn; i++) xm[i] = xn[i];
        end
    endtask

    task automatic put(input int addr, input int val);
        @(negedge clk);
        tb_we = 1'b1; tb_a = AW'(addr); tb_d = DW'(val);
    endtask

    task automatic load_hdr(input int n, input int m, input int h, input int s);
        put(0, n); put(1, m); put(2, h); put(3, s);
        @(negedge clk); tb_we = 1'b0;
    endtask

    task automatic load_data();
        for (int i = 0; i < cn; i++) begin
            for (int j = 0; j < cn; j++) put(AB + i*cn + j, am[i][j]);
            for (int k = 0; k < cm; k++) put(BB + i*cm + k, bm[i][k]);
            put(XB + i, xm[i]);
        end
        for (int k = 0; k < cm; k++) put(UB + k, um[k]);
        load_hdr(cn, cm, ch, cs);
    endtask

    task automatic run_dut(input bit hold, output int lat);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        check_eq("busy_at_start", longint'(busy), 1);
        if (!hold) start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 4000; k++) begin
            @(posedge clk); #1;
            if (done) begin lat = k; break; end
            if (!hold && k == 2) start = 1'b1;
            if (!hold && k == 3) start = 1'b0;
        end
        start = 1'b0;
        check_eq("busy_at_done", longint'(busy), 0);
    endtask

    // load scenario, run once, compare against the reference model
    task automatic do_case(input string nm, input bit bad, input bit hold);
        int lat, exp_l, wr0, dc0;
        wr0 = wr_cnt; dc0 = done_cnt;
        m_ovf = 1'b0;
        if (!bad) begin
            load_data();
            model_steps(cs);
            exp_l = 4 + cs * cn * (cn + cm + 5);
        end else begin
            load_hdr(cn, cm, ch, cs);
            exp_l = 4;
        end
        wr0 = wr_cnt; dc0 = done_cnt;
        run_dut(hold, lat);
        repeat (3) @(posedge clk);
        #1;
        check_eq({nm, "_latency"}, lat, exp_l);
        check_eq({nm, "_err"}, longint'(err), longint'(bad));
        check_eq({nm, "_ovf"}, longint'(ovf), longint'(m_ovf));
        check_eq({nm, "_writes"}, wr_cnt - wr0, bad ? 0 : cs * cn);
        check_eq({nm, "_dones"}, done_cnt - dc0, 1);
        check_eq({nm, "_idle_busy"}, longint'(busy), 0);
        if (!bad)
            for (int i = 0; i < cn; i++)
                check_eq($sformatf("%s_x%0d", nm, i), longint'($signed(mem[XB + i])), xm[i]);
    endtask

    task automatic clear_model();
        for (int i = 0; i < MAXN; i++) begin
            xm[i] = 0; um[i] = 0;
            for (int j = 0; j < MAXN; j++) begin am[i][j] = 0; bm[i][j] = 0; end
        end
    endtask

    function automatic int rnd_val(input bit big);
        if (big) return int'($urandom_range(0, 65535)) - 32768;
        else     return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    initial begin
        int lat;
        rst = 1'b1; start = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", longint'(busy), 0);
        check_eq("rst_done", longint'(done), 0);
        check_eq("rst_err", longint'(err), 0);
        check_eq("rst_ovf", longint'(ovf), 0);
        check_eq("rst_wr_en", longint'(wr_en), 0);
        check_eq("rst_rd_add1", longint'(rd_add1), 0);
        check_eq("rst_rd_add2", longint'(rd_add2), 0);
        check_eq("rst_wr_add", longint'(wr_add), 0);
        check_eq("rst_wr_data", longint'(wr_data), 0);
        @(negedge clk); rst = 1'b0;

        // scalar: 0x0200 + 0.5*0x0200 = 0x0300, latency 11
        cn = 1; cm = 1; ch = 128; cs = 1; am[0][0] = 256; xm[0] = 512;
        do_case("scalar", 1'b0, 1'b0);
        check_eq("scalar_x_const", longint'(mem[XB]), 16'h0300);

        // multi-step with START held high through DONE
        clear_model();
        cn = 2; cm = 1; ch = 64; cs = 4; bm[0][0] = 256; bm[1][0] = 256; um[0] = 256;
        do_case("multi", 1'b0, 1'b1);
        check_eq("multi_x0_const", longint'(mem[XB]), 16'h0100);
        check_eq("multi_x1_const", longint'(mem[XB + 1]), 16'h0100);

        // saturation both directions, m = 0
        clear_model();
        cn = 1; cm = 0; ch = 256; cs = 1; am[0][0] = 256; xm[0] = 28672;
        do_case("sat_pos", 1'b0, 1'b0);
        check_eq("sat_pos_const", longint'(mem[XB]), 16'h7FFF);
        xm[0] = -28672;
        do_case("sat_neg", 1'b0, 1'b0);
        check_eq("sat_neg_const", longint'(mem[XB]), 16'h8000);

        // rejected headers
        cn = 0; cm = 1; ch = 1; cs = 1;  do_case("bad_n0", 1'b1, 1'b0);
        cn = MAXN + 1;                   do_case("bad_nbig", 1'b1, 1'b0);
        cn = 1; cm = MAXM + 1;           do_case("bad_mbig", 1'b1, 1'b0);
        cm = 1; cs = 0;                  do_case("bad_steps0", 1'b1, 1'b0);

        // reset in the middle of step 2 (MAC_A of step 2 begins at E0+10)
        clear_model();
        cn = 1; cm = 1; ch = 128; cs = 3; am[0][0] = 256; xm[0] = 512;
        load_data();
        m_ovf = 1'b0;
        model_steps(1);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        #2; rst = 1'b1;
        #1;
        check_eq("abort_busy", longint'(busy), 0);
        check_eq("abort_done", longint'(done), 0);
        check_eq("abort_wr_en", longint'(wr_en), 0);
        check_eq("abort_rd_add1", longint'(rd_add1), 0);
        check_eq("abort_rd_add2", longint'(rd_add2), 0);
        check_eq("abort_wr_add", longint'(wr_add), 0);
        @(negedge clk); rst = 1'b0;
        check_eq("abort_x_step1", longint'($signed(mem[XB])), xm[0]);
        check_eq("abort_x_const", longint'(mem[XB]), 16'h0300);
        do_case("after_abort", 1'b0, 1'b0);

        // randomized scenarios
        for (int t = 0; t < 10; t++) begin
            bit big;
            clear_model();
            big = (t % 3 == 2);
            cn = int'($urandom_range(1, MAXN));
            cm = int'($urandom_range(0, MAXM));
            cs = int'($urandom_range(1, 3));
            ch = int'($urandom_range(0, 383)) - 64;
            for (int i = 0; i < cn; i++) begin
                xm[i] = rnd_val(big);
                for (int j = 0; j < cn; j++) am[i][j] = rnd_val(big);
                for (int k = 0; k < cm; k++) bm[i][k] = rnd_val(big);
            end
            for (int k = 0; k < cm; k++) um[k] = rnd_val(big);
            do_case($sformatf("rand%0d", t), 1'b0, t[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
